// File: rtl/gemvtile_pkg.sv
// gemvtile_pkg: shared tile-controller widths, issue entry layout and arbiter states.
package gemvtile_pkg;
    localparam int CTRL_INSTR_WIDTH = 32;
    localparam int CTRL_TOKEN_WIDTH = 16;
    typedef struct packed {
        logic [CTRL_INSTR_WIDTH-1:0] instr;
        logic [CTRL_TOKEN_WIDTH-1:0] token;
        logic                        last;
    } issue_entry_t;
    typedef enum logic [1:0] {ARB, BURST, GAP} arb_state_t;
endpackage

// File: rtl/gemvtile_issue_fifo.sv
// gemvtile_issue_fifo: per-requester sync FIFO of issue entries with async reset.
module gemvtile_issue_fifo
    import gemvtile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  issue_entry_t entry,
    output logic         full,
    output logic         empty,
    output issue_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    issue_entry_t mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0] count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage carries no reset; clearing the pointers is what empties the FIFO.
    always_ff @(posedge clk) if (push) mem[wrPtr] <= entry;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rdPtr];
endmodule

// File: rtl/gemvtile_issue_arbiter.sv
// gemvtile_issue_arbiter: round-robin issue of two requester FIFOs onto one tile port, atomic bursts.
module gemvtile_issue_arbiter
    import gemvtile_pkg::*;
#(
    parameter int INSTR_W    = CTRL_INSTR_WIDTH,
    parameter int TOKEN_W    = CTRL_TOKEN_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] reqA_instr,
    input  logic [TOKEN_W-1:0] reqA_token,
    input  logic               reqA_last,
    input  logic               reqA_valid,
    output logic               reqA_ready,
    input  logic [INSTR_W-1:0] reqB_instr,
    input  logic [TOKEN_W-1:0] reqB_token,
    input  logic               reqB_last,
    input  logic               reqB_valid,
    output logic               reqB_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [TOKEN_W-1:0] token_out,
    output logic               outValid,
    input  logic               tileBusy,
    output logic               grantB,
    output logic               locked
);
    localparam int GW = ISSUE_GAP > 1 ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(ISSUE_GAP > 0 ? ISSUE_GAP - 1 : 0);
    issue_entry_t entA, entB, headA, headB, headSel;
    logic fullA, fullB, emptyA, emptyB, popA, popB;
    logic live, rrPtr, pickB, issue, nextLocked;
    logic [GW-1:0] gapCnt;
    arb_state_t state, nextState;
    assign entA = '{instr: reqA_instr, token: reqA_token, last: reqA_last};
    assign entB = '{instr: reqB_instr, token: reqB_token, last: reqB_last};
    // Ready is held low through reset and only opens on the first edge after release.
    assign reqA_ready = live && !fullA;
    assign reqB_ready = live && !fullB;
    gemvtile_issue_fifo #(.DEPTH(FIFO_DEPTH)) fifoA (
        .clk(clk), .rst(rst), .push(reqA_valid && reqA_ready), .pop(popA),
        .entry(entA), .full(fullA), .empty(emptyA), .head(headA)
    );
    gemvtile_issue_fifo #(.DEPTH(FIFO_DEPTH)) fifoB (
        .clk(clk), .rst(rst), .push(reqB_valid && reqB_ready), .pop(popB),
        .entry(entB), .full(fullB), .empty(emptyB), .head(headB)
    );
    always_comb begin
        pickB = (state == BURST) ? grantB : (!emptyB && (emptyA || rrPtr));
        headSel = pickB ? headB : headA;
        issue = (state != GAP) && !tileBusy && !(pickB ? emptyB : emptyA);
        popA = issue && !pickB;
        popB = issue && pickB;
        nextLocked = issue ? !headSel.last : locked;
        nextState = (state == GAP) ? ((gapCnt == '0) ? (locked ? BURST : ARB) : GAP) :
                    !issue ? state :
                    (ISSUE_GAP > 0) ? GAP : (nextLocked ? BURST : ARB);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live        <= 1'b0;
            state       <= ARB;
            rrPtr       <= 1'b0;
            locked      <= 1'b0;
            grantB      <= 1'b0;
            outValid    <= 1'b0;
            instruction <= '0;
            token_out   <= '0;
            gapCnt      <= '0;
        end else begin
            live     <= 1'b1;
            state    <= nextState;
            locked   <= nextLocked;
            outValid <= issue;
            if (issue) begin
                instruction <= headSel.instr;
                token_out   <= headSel.token;
                grantB      <= pickB;
                gapCnt      <= GAP_INIT;
                if (headSel.last) rrPtr <= !pickB;
            end else if (state == GAP && gapCnt != '0) begin
                gapCnt <= gapCnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gemvtile_issue_arbiter.sv
// tb_gemvtile_issue_arbiter: directed scoreboard bench for the two-requester tile issue arbiter.
module tb_gemvtile_issue_arbiter;
    logic clk = 0, rst = 1;
    logic [31:0] reqA_instr = 0, reqB_instr = 0, instruction;
    logic [15:0] reqA_token = 0, reqB_token = 0, token_out;
    logic reqA_last = 0, reqA_valid = 0, reqA_ready, reqB_last = 0, reqB_valid = 0, reqB_ready;
    logic outValid, tileBusy = 0, grantB, locked;
    typedef struct packed {logic [31:0] i; logic [15:0] t; logic g;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, cyc = 0, lastPulse = -1, pe;
    logic prevOv = 0;
    bit gapChk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gemvtile_issue_arbiter dut (
        .clk(clk), .rst(rst),
        .reqA_instr(reqA_instr), .reqA_token(reqA_token), .reqA_last(reqA_last),
        .reqA_valid(reqA_valid), .reqA_ready(reqA_ready),
        .reqB_instr(reqB_instr), .reqB_token(reqB_token), .reqB_last(reqB_last),
        .reqB_valid(reqB_valid), .reqB_ready(reqB_ready),
        .instruction(instruction), .token_out(token_out), .outValid(outValid),
        .tileBusy(tileBusy), .grantB(grantB), .locked(locked)
    );

    function automatic logic [15:0] tok(input logic [31:0] i);
        return i[15:0] + 16'h0100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ex(input logic [31:0] i, input logic g);
        sb.push_back({i, tok(i), g});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (outValid) begin
            if (sb.size() == 0) chk("unexpected_issue", {32'd0, instruction}, 64'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("instr", {32'd0, instruction}, {32'd0, e.i});
                chk("token", {48'd0, token_out}, {48'd0, e.t});
                chk("grantB", {63'd0, grantB}, {63'd0, e.g});
            end
            chk("no_back_to_back", {63'd0, prevOv}, 64'd0);
            if (gapChk && lastPulse >= 0) chk("pulse_spacing", 64'(cyc - lastPulse), 64'd2);
            lastPulse = cyc;
        end
        prevOv = outValid;
    end

    task automatic cycAB(input logic av, input logic [31:0] ai, input logic al,
                         input logic bv, input logic [31:0] bi, input logic bl);
        reqA_valid = av; reqA_instr = ai; reqA_token = tok(ai); reqA_last = al;
        reqB_valid = bv; reqB_instr = bi; reqB_token = tok(bi); reqB_last = bl;
        if (av) chk("readyA_push", {63'd0, reqA_ready}, 64'd1);
        if (bv) chk("readyB_push", {63'd0, reqB_ready}, 64'd1);
        @(posedge clk); #1;
        reqA_valid = 0; reqB_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
        chk("drain_done", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with A presenting a valid entry
        reqA_valid = 1; reqA_instr = 32'hDEAD;
        repeat (3) begin
            @(negedge clk);
            chk("rst_readyA", {63'd0, reqA_ready}, 64'd0);
            chk("rst_readyB", {63'd0, reqB_ready}, 64'd0);
            chk("rst_outValid", {63'd0, outValid}, 64'd0);
            chk("rst_instr", {32'd0, instruction}, 64'd0);
            chk("rst_locked", {62'd0, grantB, locked}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 0; reqA_valid = 0;
        chk("ready_held_at_release", {63'd0, reqA_ready}, 64'd0);
        @(posedge clk); #1;
        chk("ready_after_release", {62'd0, reqA_ready, reqB_ready}, 64'd3);
        // 2: single A entry, 2-cycle latency
        ex(32'h11, 0);
        cycAB(1, 32'h11, 1, 0, 0, 0);
        pe = cyc;
        drain();
        chk("latency", 64'(lastPulse - pe + 1), 64'd2);
        // 3: round robin, outValid every 2 cycles
        resetDut();
        ex(32'hA1, 0); ex(32'hB1, 1); ex(32'hA2, 0); ex(32'hB2, 1); ex(32'hA3, 0); ex(32'hB3, 1);
        gapChk = 1; lastPulse = -1;
        cycAB(1, 32'hA1, 1, 1, 32'hB1, 1);
        cycAB(1, 32'hA2, 1, 1, 32'hB2, 1);
        cycAB(1, 32'hA3, 1, 1, 32'hB3, 1);
        drain();
        gapChk = 0;
        // 4: atomic burst holds off B until A's last entry
        ex(32'h20, 0); ex(32'h21, 0); ex(32'h22, 0); ex(32'h30, 1);
        cycAB(1, 32'h20, 0, 1, 32'h30, 1);
        cycAB(1, 32'h21, 0, 0, 0, 0);
        chk("burst_first_issue", {62'd0, outValid, locked}, 64'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("burst_waits_owner", {62'd0, outValid, locked}, 64'd1);
        cycAB(1, 32'h22, 1, 0, 0, 0);
        drain();
        chk("burst_unlocked", {63'd0, locked}, 64'd0);
        // 5: backpressure with tile busy
        tileBusy = 1;
        for (int i = 0; i < 5; i++) begin
            reqB_valid = 1; reqB_instr = 32'h60 + i; reqB_token = tok(32'h60 + i); reqB_last = 1;
            chk("bp_readyB", {63'd0, reqB_ready}, 64'(i < 4));
            if (i < 4) ex(32'h60 + i, 1);
            @(posedge clk); #1;
            chk("bp_no_issue", {63'd0, outValid}, 64'd0);
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {62'd0, outValid, reqB_ready}, 64'd0);
        end
        tileBusy = 0;
        begin
            int n = 0;
            while (!reqB_ready && n < 20) begin @(posedge clk); #1; n++; end
        end
        chk("bp_fifth_ready", {63'd0, reqB_ready}, 64'd1);
        ex(32'h64, 1);
        @(posedge clk); #1;
        reqB_valid = 0;
        drain();
        // 6: reset mid-burst drops the burst and A's queued tail
        ex(32'h40, 0);
        cycAB(1, 32'h40, 0, 0, 0, 0);
        cycAB(1, 32'h41, 1, 0, 0, 0);
        chk("mid_burst_locked", {62'd0, outValid, locked}, 64'd3);
        @(negedge clk); #1;
        rst = 1;
        #1;
        chk("rst_mid_locked", {61'd0, locked, outValid, reqA_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        ex(32'h50, 1);
        cycAB(0, 0, 0, 1, 32'h50, 1);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
